// File: rtl/enc_pkg.sv
// enc_pkg: shared types and sizing for the sequential priority encoder
package enc_pkg;
  typedef enum logic [0:0] {IDLE, PRESENT} state_t;
  localparam int N_DEF = 8;
  localparam int W_DEF = $clog2(N_DEF);
endpackage

// File: rtl/enc_pick.sv
// enc_pick: combinational picker, fixed highest-first or rotating from base (ENC_ROUND_ROBIN_EN)
module enc_pick
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] base,
  output logic [W-1:0] idx,
  output logic         found
);
  // later assignments win, so scanning k downward leaves the nearest hit to base
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
`ifdef ENC_ROUND_ROBIN_EN
      if (cand[base + W'(k)]) idx = base + W'(k);
`else
      if (cand[base - W'(k + 1)]) idx = base - W'(k + 1);
`endif
    end
  end
  assign found = |cand;
endmodule

// File: rtl/enc8to3_seq.sv
// enc8to3_seq: sequential priority encoder with valid/ready code issue; ENC_ROUND_ROBIN_EN selects rotating priority
module enc8to3_seq
  import enc_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         code_valid,
  input  logic         code_ready,
  output logic [N-1:0] pending,
  output logic         any_pending
);
  state_t       state;
  logic         accept;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] base;
  logic [W-1:0] pick;
  logic         found;
  assign accept     = code_valid && code_ready;
  assign clr        = accept ? (N'(1) << code) : '0;
  assign cand       = (pending & ~clr) | (en ? req : '0);
  assign code_valid = state == PRESENT;
`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] last_idx;
  assign base = (accept ? code : last_idx) + W'(1);
  // remembers the last accepted index so the search starts just past it
  always_ff @(posedge clk or posedge rst)
    if (rst) last_idx <= '1;
    else if (accept) last_idx <= code;
`else
  assign base = '0;
`endif
  enc_pick #(.N(N)) u_pick (
    .cand  (cand),
    .base  (base),
    .idx   (pick),
    .found (found)
  );
  // pending capture plus IDLE/PRESENT handshake; a new pick loads only when nothing is held
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending     <= '0;
      any_pending <= 1'b0;
      code        <= '0;
      state       <= IDLE;
    end else begin
      pending     <= cand;
      any_pending <= |cand;
      if (found && (state == IDLE || accept)) begin
        code  <= pick;
        state <= PRESENT;
      end else if (accept) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_enc8to3_seq.sv
// tb_enc8to3_seq: directed and random checks of enc8to3_seq against a behavioural model
module tb_enc8to3_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       code_ready = 1'b0;
  logic [2:0] code;
  logic       code_valid;
  logic [7:0] pending;
  logic       any_pending;
  int n_assert = 0;
  int n_fail = 0;
  bit [7:0] m_pend;
  bit       m_valid;
  int       m_code;
  int       m_last;

  enc8to3_seq dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .any_pending(any_pending)
  );

  always #5 clk = ~clk;

  function automatic int choose(input bit [7:0] p, input int last);
`ifdef ENC_ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) if (p[(last + k) % 8]) return (last + k) % 8;
`else
    for (int i = 7; i >= 0; i--) if (p[i]) return i;
`endif
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_valid = 0; m_code = 0; m_last = 7;
  endtask

  task automatic model_edge();
    bit acc;
    acc = m_valid && code_ready;
    if (acc) begin
      m_pend[m_code] = 1'b0;
      m_last = m_code;
    end
    if (en) m_pend = m_pend | req;
    if (m_pend != 0 && (!m_valid || acc)) begin
      m_code = choose(m_pend, m_last);
      m_valid = 1;
    end else if (acc) m_valid = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("code_valid", 32'(code_valid), 32'(m_valid));
    chk("code", 32'(code), m_code);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("any_pending", 32'(any_pending), 32'(m_pend != 0));
  endtask

  task automatic step(input logic e, input logic [7:0] r, input logic rdy);
    en = e; req = r; code_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'h04, 1);
`ifndef ENC_ROUND_ROBIN_EN
    chk("single_code", 32'(code), 2);
`endif
    step(0, 8'h00, 1);
    chk("single_idle", 32'(code_valid), 0);
    step(1, 8'h85, 1);
    step(0, 8'h00, 1);
`ifndef ENC_ROUND_ROBIN_EN
    chk("multi_second", 32'(code), 2);
`endif
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("multi_idle", 32'(code_valid), 0);
    step(1, 8'h04, 0);
    step(1, 8'h40, 0);
    chk("no_preempt", 32'(code), 2);
    step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(1, 8'h08, 1);
    step(1, 8'h08, 1);
    chk("reissue_pend3", 32'(pending[3]), 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step(1, 8'hFF, 1);
`ifndef ENC_ROUND_ROBIN_EN
    chk("ff_fixed", 32'(code), 7);
`endif
    step(0, 8'h00, 1);
    step(1, 8'h13, 0);
    chk("pre_reset_valid", 32'(code_valid), 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 3) != 0), 8'($urandom) & 8'($urandom), logic'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 12; i++) step(0, 8'h00, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
